// File: rtl/slc3_mem_arbiter_pkg.sv
// Shared types and defaults for the SLC-3 BRAM arbiter slice.
// Arbiter FSM states, port identifiers and default bus widths.
package slc3_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_RD_LAT = 2;
    // Wide enough for RD_LAT-1 with RD_LAT up to 4.
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } owner_t;

endpackage

// File: rtl/slc3_mem_arbiter_rr_arb2.sv
// Two-requester round-robin pick: a lone requester wins outright,
// and under contention the port that did not win last time is chosen.
module rr_arb2 (
    input  logic a_req,
    input  logic b_req,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = a_req | b_req;
        if (a_req && b_req) begin
            grant = ~last_grant;
        end else begin
            grant = b_req;
        end
    end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Shares one single-port synchronous BRAM between the CPU (port A) and the
// debug/loader path (port B), hiding the read latency behind req/ack.
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy,
    output logic              owner
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic arb_grant;
    logic arb_valid;

    rr_arb2 u_rr_arb2 (
        .a_req      (a_req),
        .b_req      (b_req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            owner_q      <= PORT_A;
            last_grant_q <= PORT_B;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        bram_en      = 1'b0;
        bram_we      = 1'b0;
        a_ack        = 1'b0;
        b_ack        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d      = owner_t'(arb_grant);
                    last_grant_d = owner_t'(arb_grant);
                    if (arb_grant) begin
                        we_d    = b_we;
                        addr_d  = b_addr;
                        wdata_d = b_wdata;
                    end else begin
                        we_d    = a_we;
                        addr_d  = a_addr;
                        wdata_d = a_wdata;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bram_en = 1'b1;
                bram_we = we_q;
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Capture lands on the last WAIT cycle, when dout is valid.
                if (cnt_q == '0) begin
                    if (owner_q == PORT_A) begin
                        a_rdata_d = bram_dout;
                    end else begin
                        b_rdata_d = bram_dout;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            ACK: begin
                a_ack   = (owner_q == PORT_A);
                b_ack   = (owner_q == PORT_B);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bram_addr = addr_q;
    assign bram_din  = wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

endmodule

// File: doc/slc3_mem_arbiter.md
Name: slc3_mem_arbiter

Overview:
Controller that shares the single-port synchronous on-chip BRAM between two requesters. Port A is the SLC-3 CPU MAR/MDR path; port B is the debug/program-loader path. The block serialises accesses and owns the BRAM read latency, so requesters see a plain req/ack handshake. The ISDU holds its memory state until a_ack, instead of counting wait states itself.

Parameters:
ADDR_W, 16, address width of BRAM and both ports
DATA_W, 16, data width
RD_LAT, 2, BRAM read latency in cycles from address sample to valid dout (sync read plus output register); legal 1..4

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_ack
a_we  in  1  1=write, 0=read
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  one-cycle completion pulse
a_rdata  out  DATA_W  read data, valid with a_ack, held until next port A read completes
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM address
bram_din  out  DATA_W  BRAM write data
bram_dout  in  DATA_W  BRAM read data
busy  out  1  high in any state other than IDLE
owner  out  1  0=A, 1=B; current/last granted port

Behaviour:
- Reset (synchronous, dominant in any state):
  - State goes to IDLE.
  - a_ack, b_ack, bram_en, bram_we and busy are 0. bram_addr, bram_din, a_rdata and b_rdata are 0.
  - last_grant is set to B, so A wins the first contention.
  - An in-flight transaction is abandoned with no ack.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the port not equal to last_grant (round-robin).
  - On grant: latch we, addr, wdata and owner; update last_grant; next state ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle):
  - bram_en=1, bram_we=latched we, bram_addr/bram_din=latched values.
  - Write: next state ACK.
  - Read: load cnt=RD_LAT-1; next state WAIT.
- WAIT:
  - bram_en=0, bram_we=0.
  - If cnt==0: capture bram_dout into the owner's rdata register; next state ACK.
  - Else: cnt decrements; stay in WAIT.
  - WAIT therefore lasts RD_LAT cycles, and capture happens on the last one.
- ACK (1 cycle):
  - Pulse the owner's ack; next state IDLE.
  - The non-owner ack stays 0.
- Latency, counted from the first cycle req is high while the arbiter is in IDLE and uncontested:
  - Write: ack in cycle +2.
  - Read: ack in cycle +RD_LAT+2 (+4 at default).
- Requester rule: req must drop in the cycle after ack. A req still high in IDLE is a new transaction; the back-to-back repeat is legal and intended.
- Losing requester: keeps req asserted and is served after the current transaction, worst case one transaction wait. There is no starvation under continuous dual requests, because grants alternate A,B,A,B.
- Req deasserted before ack: protocol violation with undefined result. It must not hang the FSM, which always completes the latched transaction.
- One BRAM access in flight at a time; no pipelining across requesters.
- rdata of a port changes only on that port's read capture. Writes leave rdata unchanged.
- Address is used unmodified; wrap is inherent in ADDR_W.

Decomposition:
- Package slc3_mem_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT, ACK).
  - owner_t (PORT_A=0, PORT_B=1).
  - ADDR_W/DATA_W defaults.
- Sub-module rr_arb2: combinational two-requester round-robin pick from (a_req, b_req, last_grant), producing grant and valid.
- FSM, latches and counters stay in slc3_mem_arbiter.

Test Plan:
- A read, BRAM preloaded mem[0x0010]=0x1234, RD_LAT=2: a_req high at cycle 0 → bram_en=1 at cycle 1; a_ack pulses at cycle 4 with a_rdata=0x1234; b_ack stays 0.
- B write 0x0020←0xBEEF, then A read 0x0020: b_ack at +2, bram_we=1 only in the ISSUE cycle → a_rdata=0xBEEF; b_rdata unchanged.
- Both ports hold read req continuously (A: 0x0001, B: 0x0002): ack order A,B,A,B; no two consecutive acks to the same port; owner toggles each transaction.
- Reset asserted during WAIT of an A read: no a_ack; bram_en=0 and busy=0 the next cycle. A following B request is then granted with normal latency, because last_grant reset to B makes A preferred only under contention.
- A holds a_req through ack with a_we=0 → second read issues; two a_ack pulses 5 cycles apart (ACK→IDLE→ISSUE→WAIT×2→ACK).
- RD_LAT=1 build: A read of mem[0x00FF]=0x00AA → a_ack at cycle 3, value 0x00AA.
